// File: rtl/pipe_stage_regs_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs_if
//   Groups every non-clock signal of the Y86-64 pipeline register bank.
//   Stall/bubble controls, the stage-to-register buses and the registered
//   stage outputs all travel together.
//
//   Parameter
//     DW        datapath word width
//
//   Signals (direction as seen by the register bank, modport slave)
//     F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall   in
//     f_predPC  in   DW        next predicted PC from fetch
//     f_bus     in   19+2DW    {stat,icode,ifun,rA,rB,valC,valP}
//     d_bus     in   27+3DW    {stat,icode,ifun,valC,valA,valB,dstE,dstM,srcA,srcB}
//     e_bus     in   16+2DW    {stat,icode,Cnd,valE,valA,dstE,dstM}
//     m_bus     in   15+2DW    {stat,icode,valE,valM,dstE,dstM}
//     F_predPC  out  DW        registered predPC
//     D_bus/E_bus/M_bus/W_bus  out  registered stage contents
//     ctl_err   out  1         sticky illegal stall+bubble flag
//     bub_cnt   out  32        saturating bubble count
//     stl_cnt   out  32        saturating stall-cycle count
//
//   modport master : the surrounding pipeline (drives inputs, reads outputs)
//   modport slave  : the register bank
// ---------------------------------------------------------------------------
interface pipe_stage_regs_if #(
    parameter int DW = 64
);
    logic                F_stall;
    logic                D_stall;
    logic                D_bubble;
    logic                E_bubble;
    logic                M_bubble;
    logic                W_stall;

    logic [DW-1:0]       f_predPC;
    logic [19+2*DW-1:0]  f_bus;
    logic [27+3*DW-1:0]  d_bus;
    logic [16+2*DW-1:0]  e_bus;
    logic [15+2*DW-1:0]  m_bus;

    logic [DW-1:0]       F_predPC;
    logic [19+2*DW-1:0]  D_bus;
    logic [27+3*DW-1:0]  E_bus;
    logic [16+2*DW-1:0]  M_bus;
    logic [15+2*DW-1:0]  W_bus;
    logic                ctl_err;
    logic [31:0]         bub_cnt;
    logic [31:0]         stl_cnt;

    modport master (
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output f_predPC, f_bus, d_bus, e_bus, m_bus,
        input  F_predPC, D_bus, E_bus, M_bus, W_bus, ctl_err, bub_cnt, stl_cnt
    );

    modport slave (
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  f_predPC, f_bus, d_bus, e_bus, m_bus,
        output F_predPC, D_bus, E_bus, M_bus, W_bus, ctl_err, bub_cnt, stl_cnt
    );
endinterface

// File: rtl/pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs
//   Y86-64 pipeline register bank for the F, D, E, M and W stages. Each
//   stage register loads, holds (stall) or takes a nop bubble every cycle,
//   as directed by the hazard-control logic. Everything is registered: no
//   combinational path exists from any input to any output.
//
//   Parameters
//     DW      datapath word width
//     RST_PC  predPC value loaded at reset
//
//   Ports
//     clk     rising-edge clock
//     rst     synchronous, active-high reset (clears every stage to a bubble)
//     bus_if  pipe_stage_regs_if.slave: controls, stage input buses,
//             registered stage outputs, ctl_err, bub_cnt, stl_cnt
//
//   Per-stage priority: reset > stall > bubble > load.
//     F: stall or load          D: stall, bubble or load
//     E: bubble or load         M: bubble or load
//     W: stall or load
// ---------------------------------------------------------------------------
module pipe_stage_regs #(
    parameter int            DW     = 64,
    parameter logic [DW-1:0] RST_PC = '0
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_regs_if.slave bus_if
);

    localparam int FW = 19 + 2 * DW;   // F -> D bus
    localparam int DB = 27 + 3 * DW;   // D -> E bus
    localparam int EB = 16 + 2 * DW;   // E -> M bus
    localparam int MB = 15 + 2 * DW;   // M -> W bus

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [DW-1:0] ZW    = '0;

    // Bubble images: stat=BUB, icode=NOP, ifun/Cnd=0, register ids RNONE,
    // every value field zero.
    localparam logic [FW-1:0] D_NOP = {STAT_BUB, I_NOP, 4'h0, RNONE, RNONE, ZW, ZW};
    localparam logic [DB-1:0] E_NOP = {STAT_BUB, I_NOP, 4'h0, ZW, ZW, ZW,
                                       RNONE, RNONE, RNONE, RNONE};
    localparam logic [EB-1:0] M_NOP = {STAT_BUB, I_NOP, 1'b0, ZW, ZW, RNONE, RNONE};
    localparam logic [MB-1:0] W_NOP = {STAT_BUB, I_NOP, ZW, ZW, RNONE, RNONE};

    // Unsigned add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                              input logic [1:0]  inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [DW-1:0] f_pc_q,    f_pc_d;
    logic [FW-1:0] d_reg_q,   d_reg_d;
    logic [DB-1:0] e_reg_q,   e_reg_d;
    logic [EB-1:0] m_reg_q,   m_reg_d;
    logic [MB-1:0] w_reg_q,   w_reg_d;
    logic          ctl_err_q, ctl_err_d;
    logic [31:0]   bub_cnt_q, bub_cnt_d;
    logic [31:0]   stl_cnt_q, stl_cnt_d;

    logic [1:0]    bub_inc;
    logic          any_stall;

    // ---- next-state: stage registers ----
    always_comb begin
        f_pc_d = bus_if.F_stall ? f_pc_q : bus_if.f_predPC;

        if (bus_if.D_stall) begin
            d_reg_d = d_reg_q;
        end else if (bus_if.D_bubble) begin
            d_reg_d = D_NOP;
        end else begin
            d_reg_d = bus_if.f_bus;
        end

        e_reg_d = bus_if.E_bubble ? E_NOP : bus_if.d_bus;
        m_reg_d = bus_if.M_bubble ? M_NOP : bus_if.e_bus;
        w_reg_d = bus_if.W_stall  ? w_reg_q : bus_if.m_bus;
    end

    // ---- next-state: status and counters ----
    always_comb begin
        // A D bubble masked by a D stall never reaches the register, so it
        // is not counted.
        bub_inc   = {1'b0, bus_if.D_bubble & ~bus_if.D_stall}
                  + {1'b0, bus_if.E_bubble}
                  + {1'b0, bus_if.M_bubble};
        any_stall = bus_if.F_stall | bus_if.D_stall | bus_if.W_stall;

        bub_cnt_d = sat_add32(bub_cnt_q, bub_inc);
        stl_cnt_d = sat_add32(stl_cnt_q, {1'b0, any_stall});
        ctl_err_d = ctl_err_q | (bus_if.D_stall & bus_if.D_bubble);
    end

    // ---- state registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            f_pc_q    <= RST_PC;
            d_reg_q   <= D_NOP;
            e_reg_q   <= E_NOP;
            m_reg_q   <= M_NOP;
            w_reg_q   <= W_NOP;
            ctl_err_q <= 1'b0;
            bub_cnt_q <= 32'd0;
            stl_cnt_q <= 32'd0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_reg_q   <= d_reg_d;
            e_reg_q   <= e_reg_d;
            m_reg_q   <= m_reg_d;
            w_reg_q   <= w_reg_d;
            ctl_err_q <= ctl_err_d;
            bub_cnt_q <= bub_cnt_d;
            stl_cnt_q <= stl_cnt_d;
        end
    end

    // ---- registered outputs ----
    assign bus_if.F_predPC = f_pc_q;
    assign bus_if.D_bus    = d_reg_q;
    assign bus_if.E_bus    = e_reg_q;
    assign bus_if.M_bus    = m_reg_q;
    assign bus_if.W_bus    = w_reg_q;
    assign bus_if.ctl_err  = ctl_err_q;
    assign bus_if.bub_cnt  = bub_cnt_q;
    assign bus_if.stl_cnt  = stl_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_regs
//   Directed scenarios plus randomized traffic for pipe_stage_regs, checked
//   every cycle against a field-level reference model of the stage rules.
// ---------------------------------------------------------------------------
module tb_pipe_stage_regs;
    localparam int            DW     = 64;
    localparam logic [DW-1:0] RST_PC = 64'h0000_0000_0000_0100;
    localparam int FW = 19 + 2 * DW;
    localparam int DB = 27 + 3 * DW;
    localparam int EB = 16 + 2 * DW;
    localparam int MB = 15 + 2 * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_regs_if #(.DW(DW)) bif ();

    pipe_stage_regs #(.DW(DW), .RST_PC(RST_PC)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bif)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Field packers, named after the Y86 stage register contents.
    function automatic logic [FW-1:0] mk_d(logic [2:0] stat, logic [3:0] icode, logic [3:0] ifun,
                                           logic [3:0] rA, logic [3:0] rB,
                                           logic [DW-1:0] valC, logic [DW-1:0] valP);
        return {stat, icode, ifun, rA, rB, valC, valP};
    endfunction
    function automatic logic [DB-1:0] mk_e(logic [2:0] stat, logic [3:0] icode, logic [3:0] ifun,
                                           logic [DW-1:0] valC, logic [DW-1:0] valA,
                                           logic [DW-1:0] valB, logic [3:0] dstE,
                                           logic [3:0] dstM, logic [3:0] srcA, logic [3:0] srcB);
        return {stat, icode, ifun, valC, valA, valB, dstE, dstM, srcA, srcB};
    endfunction
    function automatic logic [EB-1:0] mk_m(logic [2:0] stat, logic [3:0] icode, logic cnd,
                                           logic [DW-1:0] valE, logic [DW-1:0] valA,
                                           logic [3:0] dstE, logic [3:0] dstM);
        return {stat, icode, cnd, valE, valA, dstE, dstM};
    endfunction
    function automatic logic [MB-1:0] mk_w(logic [2:0] stat, logic [3:0] icode,
                                           logic [DW-1:0] valE, logic [DW-1:0] valM,
                                           logic [3:0] dstE, logic [3:0] dstM);
        return {stat, icode, valE, valM, dstE, dstM};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model state.
    logic [DW-1:0] m_pc;
    logic [FW-1:0] m_d;
    logic [DB-1:0] m_e;
    logic [EB-1:0] m_m;
    logic [MB-1:0] m_w;
    logic          m_err;
    logic [31:0]   m_bub, m_stl;

    function automatic logic [FW-1:0] nop_d(); return mk_d(3'd0, 4'h1, 4'h0, 4'hF, 4'hF, '0, '0); endfunction
    function automatic logic [DB-1:0] nop_e(); return mk_e(3'd0, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF); endfunction
    function automatic logic [EB-1:0] nop_m(); return mk_m(3'd0, 4'h1, 1'b0, '0, '0, 4'hF, 4'hF); endfunction
    function automatic logic [MB-1:0] nop_w(); return mk_w(3'd0, 4'h1, '0, '0, 4'hF, 4'hF); endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v, int n);
        longint t;
        t = longint'(v) + longint'(n);
        return (t > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
    endfunction

    task automatic model_next();
        int nb;
        if (rst) begin
            m_pc = RST_PC; m_d = nop_d(); m_e = nop_e(); m_m = nop_m(); m_w = nop_w();
            m_err = 1'b0; m_bub = 32'd0; m_stl = 32'd0;
        end else begin
            nb = int'(bif.D_bubble && !bif.D_stall) + int'(bif.E_bubble) + int'(bif.M_bubble);
            if (!bif.F_stall) m_pc = bif.f_predPC;
            if (!bif.D_stall) m_d = bif.D_bubble ? nop_d() : bif.f_bus;
            m_e = bif.E_bubble ? nop_e() : bif.d_bus;
            m_m = bif.M_bubble ? nop_m() : bif.e_bus;
            if (!bif.W_stall) m_w = bif.m_bus;
            if (bif.D_stall && bif.D_bubble) m_err = 1'b1;
            m_bub = sat_inc(m_bub, nb);
            if (bif.F_stall || bif.D_stall || bif.W_stall) m_stl = sat_inc(m_stl, 1);
        end
    endtask

    task automatic check_all(input bit skip_bub);
        check("F_predPC", 256'(bif.F_predPC), 256'(m_pc));
        check("D_bus",    256'(bif.D_bus),    256'(m_d));
        check("E_bus",    256'(bif.E_bus),    256'(m_e));
        check("M_bus",    256'(bif.M_bus),    256'(m_m));
        check("W_bus",    256'(bif.W_bus),    256'(m_w));
        check("ctl_err",  256'(bif.ctl_err),  256'(m_err));
        check("stl_cnt",  256'(bif.stl_cnt),  256'(m_stl));
        if (!skip_bub) check("bub_cnt", 256'(bif.bub_cnt), 256'(m_bub));
    endtask

    // Inputs are applied on the falling edge; model and DUT advance on the
    // next rising edge and are compared shortly after it.
    task automatic step(input bit skip_bub);
        model_next();
        @(posedge clk);
        #1;
        check_all(skip_bub);
        @(negedge clk);
    endtask

    task automatic set_ctl(input bit fs, input bit ds, input bit db,
                           input bit eb, input bit mb, input bit ws);
        bif.F_stall = fs; bif.D_stall = ds; bif.D_bubble = db;
        bif.E_bubble = eb; bif.M_bubble = mb; bif.W_stall = ws;
    endtask

    task automatic rand_data();
        logic [255:0] r;
        r = rnd256(); bif.f_predPC = r[DW-1:0];
        r = rnd256(); bif.f_bus    = r[FW-1:0];
        r = rnd256(); bif.d_bus    = r[DB-1:0];
        r = rnd256(); bif.e_bus    = r[EB-1:0];
        r = rnd256(); bif.m_bus    = r[MB-1:0];
    endtask

    initial begin
        logic [FW-1:0] d_before;
        logic [EB-1:0] e_before;

        set_ctl(0, 0, 0, 0, 0, 0);
        rand_data();
        @(negedge clk);

        // Reset for two cycles with controls asserted: reset must win.
        rst = 1'b1;
        set_ctl(1, 1, 1, 1, 1, 1);
        step(0);
        step(0);
        check("rst_D_icode", 256'(bif.D_bus[FW-4 -: 4]), 256'(4'h1));
        check("rst_W_stat",  256'(bif.W_bus[MB-1 -: 3]), 256'(3'd0));
        check("rst_pc",      256'(bif.F_predPC),         256'(RST_PC));

        // Plain streaming: irmovq into D, random traffic elsewhere.
        rst = 1'b0;
        set_ctl(0, 0, 0, 0, 0, 0);
        rand_data();
        bif.f_bus = mk_d(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h55, 64'h10A);
        step(0);
        check("irmovq_D", 256'(bif.D_bus), 256'(mk_d(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h55, 64'h10A)));
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step(0);
        end

        // Load-use: F and D hold, E bubbles, M takes e_bus.
        d_before = bif.D_bus;
        rand_data();
        e_before = bif.e_bus;
        set_ctl(1, 1, 0, 1, 0, 0);
        step(0);
        check("lu_D_hold", 256'(bif.D_bus), 256'(d_before));
        check("lu_M_load", 256'(bif.M_bus), 256'(e_before));
        check("lu_bub",    256'(bif.bub_cnt), 256'(32'd1));
        check("lu_stl",    256'(bif.stl_cnt), 256'(32'd1));

        // Mispredict: D and E bubble, F loads.
        rand_data();
        set_ctl(0, 0, 1, 1, 0, 0);
        step(0);
        check("mp_bub", 256'(bif.bub_cnt), 256'(32'd3));

        // ret in flight, then W exception hold.
        rand_data(); set_ctl(1, 0, 1, 0, 0, 0); step(0);
        rand_data(); set_ctl(0, 0, 0, 0, 0, 1); step(0);
        rand_data(); step(0);

        // Illegal D stall+bubble: D holds, ctl_err sticks.
        rand_data();
        set_ctl(0, 1, 1, 0, 0, 0);
        step(0);
        check("err_set", 256'(bif.ctl_err), 256'(1'b1));
        set_ctl(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step(0);
        end
        check("err_sticky", 256'(bif.ctl_err), 256'(1'b1));

        // Randomized control and data traffic, occasional reset.
        for (int i = 0; i < 400; i++) begin
            rand_data();
            set_ctl(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                    ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0);
            rst = ($urandom % 50) == 0;
            step(0);
        end
        rst = 1'b0;

        // Saturation: preload bub_cnt just below the top, then three
        // bubbles per cycle must pin it at all-ones.
        rand_data();
        set_ctl(0, 0, 1, 1, 1, 0);
        force dut.bub_cnt_q = 32'hFFFF_FFFE;
        step(1);
        release dut.bub_cnt_q;
        m_bub = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step(0);
        end
        check("sat_hold", 256'(bif.bub_cnt), 256'(32'hFFFF_FFFF));

        // Reset mid-stream discards everything.
        rand_data();
        set_ctl(1, 1, 1, 1, 1, 1);
        rst = 1'b1;
        step(0);
        check("rst2_bub", 256'(bif.bub_cnt), 256'(32'd0));
        check("rst2_err", 256'(bif.ctl_err), 256'(1'b0));
        check("rst2_E",   256'(bif.E_bus),   256'(mk_e(3'd0, 4'h1, 4'h0, '0, '0, '0,
                                                       4'hF, 4'hF, 4'hF, 4'hF)));
        rst = 1'b0;
        set_ctl(0, 0, 0, 0, 0, 0);
        rand_data();
        step(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
